// File: rtl/regbank_ctx_ctrl.sv
// Shadow-register context controller: tracks registers written during an ISR
// and copies their main-context values back into the shadow bank on return.
module regbank_ctx_ctrl #(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 64,
  localparam int AW        = $clog2(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  irq_req,
  input  logic                  irq_ret,
  input  logic                  cpu_we,
  input  logic [AW-1:0]         cpu_waddr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [AW-1:0]         cpu_raddr_a,
  input  logic [DATA_WIDTH-1:0] bank_rdata_a,
  output logic                  bank_we,
  output logic [AW-1:0]         bank_waddr,
  output logic [DATA_WIDTH-1:0] bank_wdata,
  output logic [AW-1:0]         bank_raddr_a,
  output logic                  interrupt,
  output logic                  irq_ack,
  output logic                  stall,
  output logic [AW:0]           dirty_count,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISR    = 2'd1,
    RST_RD = 2'd2,
    RST_WR = 2'd3
  } state_t;

  localparam logic [REG_NUM-1:0] ONE = REG_NUM'(1);

  state_t                state;
  logic [REG_NUM-1:0]    dirty;
  logic [REG_NUM-1:0]    dirty_nxt;
  logic [REG_NUM-1:0]    mark;
  logic [AW-1:0]         restore_idx;
  logic [AW-1:0]         hold_idx;
  logic [DATA_WIDTH-1:0] hold_data;

  function automatic logic [AW-1:0] lowest_set(input logic [REG_NUM-1:0] v);
    logic [AW-1:0] r;
    r = '0;
    for (int i = REG_NUM - 1; i >= 0; i--) begin
      if (v[i]) r = AW'(i);
    end
    return r;
  endfunction

  function automatic logic [AW:0] popcount(input logic [REG_NUM-1:0] v);
    logic [AW:0] r;
    r = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      r = r + (AW+1)'(v[i]);
    end
    return r;
  endfunction

  assign state_dbg   = state;
  assign restore_idx = lowest_set(dirty);

  // Only ISR writebacks to non-zero registers touch the shadow context.
  always_comb begin
    mark = '0;
    if (state == ISR && cpu_we && cpu_waddr != '0) mark = ONE << cpu_waddr;
  end

  always_comb begin
    dirty_nxt = dirty;
    case (state)
      ISR:     dirty_nxt = dirty | mark;
      RST_WR:  dirty_nxt = dirty & ~(ONE << hold_idx);
      default: dirty_nxt = dirty;
    endcase
    dirty_nxt[0] = 1'b0;
  end

  // While restoring, the bank ports belong to the restore engine and any CPU
  // writeback is simply dropped.
  always_comb begin
    bank_we      = cpu_we;
    bank_waddr   = cpu_waddr;
    bank_wdata   = cpu_wdata;
    bank_raddr_a = cpu_raddr_a;
    case (state)
      RST_RD: begin
        bank_we      = 1'b0;
        bank_waddr   = hold_idx;
        bank_wdata   = hold_data;
        bank_raddr_a = restore_idx;
      end
      RST_WR: begin
        bank_we      = 1'b1;
        bank_waddr   = hold_idx;
        bank_wdata   = hold_data;
        bank_raddr_a = restore_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dirty       <= '0;
      hold_idx    <= '0;
      hold_data   <= '0;
      interrupt   <= 1'b0;
      irq_ack     <= 1'b0;
      stall       <= 1'b0;
      dirty_count <= '0;
    end else begin
      dirty       <= dirty_nxt;
      dirty_count <= popcount(dirty_nxt);
      irq_ack     <= 1'b0;
      case (state)
        IDLE: begin
          if (irq_req) begin
            state     <= ISR;
            interrupt <= 1'b1;
            irq_ack   <= 1'b1;
          end
        end
        ISR: begin
          // irq_req is deliberately not looked at here: no nesting.
          if (irq_ret) begin
            interrupt <= 1'b0;
            if (dirty_nxt != '0) begin
              state <= RST_RD;
              stall <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        RST_RD: begin
          hold_idx  <= restore_idx;
          hold_data <= bank_rdata_a;
          state     <= RST_WR;
        end
        RST_WR: begin
          if (dirty_nxt != '0) begin
            state <= RST_RD;
          end else begin
            state <= IDLE;
            stall <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_ctx_ctrl.sv
// Directed bench for regbank_ctx_ctrl: ISR entry/exit, dirty tracking,
// restore sequencing, stall behaviour and asynchronous reset.
module tb_regbank_ctx_ctrl;

  localparam int REG_NUM = 32;
  localparam int DW      = 64;
  localparam int AW      = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ISR  = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic          irq_req, irq_ret, cpu_we;
  logic [AW-1:0] cpu_waddr, cpu_raddr_a;
  logic [DW-1:0] cpu_wdata, bank_rdata_a;
  logic          bank_we;
  logic [AW-1:0] bank_waddr, bank_raddr_a;
  logic [DW-1:0] bank_wdata;
  logic          interrupt, irq_ack, stall;
  logic [AW:0]   dirty_count;
  logic [1:0]    state_dbg;

  logic [DW-1:0] main_mem [REG_NUM];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign bank_rdata_a = main_mem[bank_raddr_a];

  regbank_ctx_ctrl #(.REG_NUM(REG_NUM), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .irq_ret(irq_ret),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_raddr_a(cpu_raddr_a), .bank_rdata_a(bank_rdata_a),
    .bank_we(bank_we), .bank_waddr(bank_waddr), .bank_wdata(bank_wdata),
    .bank_raddr_a(bank_raddr_a), .interrupt(interrupt), .irq_ack(irq_ack),
    .stall(stall), .dirty_count(dirty_count), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    irq_req     = 1'b0;
    irq_ret     = 1'b0;
    cpu_we      = 1'b0;
    cpu_waddr   = '0;
    cpu_wdata   = '0;
    cpu_raddr_a = '0;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_we    = 1'b1;
    cpu_waddr = a;
    cpu_wdata = d;
    tick();
    cpu_we    = 1'b0;
  endtask

  task automatic enter_isr(input string tag);
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    check({tag, "_state_isr"}, DW'(state_dbg), DW'(S_ISR));
    check({tag, "_irq_ack"}, DW'(irq_ack), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < REG_NUM; i++) main_mem[i] = {32'hC0DE_0000, 32'(i)};
    main_mem[5] = 64'hA5;
    main_mem[9] = 64'h99;
    idle_inputs();
    reset = 1'b0;
    #2;
    check("rst_interrupt", DW'(interrupt), 0);
    check("rst_irq_ack", DW'(irq_ack), 0);
    check("rst_stall", DW'(stall), 0);
    check("rst_dirty_count", DW'(dirty_count), 0);
    check("rst_state", DW'(state_dbg), DW'(S_IDLE));
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Plain ISR round trip with no writes.
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    check("rt_interrupt_on", DW'(interrupt), 1);
    check("rt_irq_ack_on", DW'(irq_ack), 1);
    tick();
    check("rt_irq_ack_off", DW'(irq_ack), 0);
    check("rt_interrupt_hold", DW'(interrupt), 1);
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
    check("rt_interrupt_off", DW'(interrupt), 0);
    check("rt_stall", DW'(stall), 0);
    check("rt_state_idle", DW'(state_dbg), DW'(S_IDLE));

    // Writes x5, x9, x5 then restore of both in ascending order.
    enter_isr("w59");
    cpu_we = 1'b1; cpu_waddr = 5'd5; cpu_wdata = 64'h1111;
    #1;
    check("w59_fwd_we", DW'(bank_we), 1);
    check("w59_fwd_waddr", DW'(bank_waddr), 5);
    check("w59_fwd_wdata", bank_wdata, 64'h1111);
    tick();
    cpu_we = 1'b0;
    check("w59_cnt1", DW'(dirty_count), 1);
    cpu_write(5'd9, 64'h2222);
    check("w59_cnt2", DW'(dirty_count), 2);
    cpu_write(5'd5, 64'h3333);
    check("w59_cnt_rewrite", DW'(dirty_count), 2);
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
    check("w59_rd1_state", DW'(state_dbg), DW'(S_RD));
    check("w59_rd1_stall", DW'(stall), 1);
    check("w59_rd1_int", DW'(interrupt), 0);
    check("w59_rd1_raddr", DW'(bank_raddr_a), 5);
    check("w59_rd1_we", DW'(bank_we), 0);
    tick();
    check("w59_wr1_stall", DW'(stall), 1);
    check("w59_wr1_we", DW'(bank_we), 1);
    check("w59_wr1_waddr", DW'(bank_waddr), 5);
    check("w59_wr1_wdata", bank_wdata, 64'hA5);
    tick();
    check("w59_rd2_stall", DW'(stall), 1);
    check("w59_rd2_cnt", DW'(dirty_count), 1);
    check("w59_rd2_raddr", DW'(bank_raddr_a), 9);
    tick();
    check("w59_wr2_stall", DW'(stall), 1);
    check("w59_wr2_waddr", DW'(bank_waddr), 9);
    check("w59_wr2_wdata", bank_wdata, 64'h99);
    tick();
    check("w59_end_stall", DW'(stall), 0);
    check("w59_end_cnt", DW'(dirty_count), 0);
    check("w59_end_state", DW'(state_dbg), DW'(S_IDLE));

    // Write to x0 is never tracked.
    enter_isr("x0");
    cpu_write(5'd0, 64'h5555);
    check("x0_cnt", DW'(dirty_count), 0);
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
    check("x0_state", DW'(state_dbg), DW'(S_IDLE));
    check("x0_stall", DW'(stall), 0);

    // Same-cycle write to x31 on return.
    enter_isr("x31");
    irq_ret = 1'b1; cpu_we = 1'b1; cpu_waddr = 5'd31; cpu_wdata = 64'h7777;
    tick();
    idle_inputs();
    check("x31_rd_state", DW'(state_dbg), DW'(S_RD));
    check("x31_cnt", DW'(dirty_count), 1);
    check("x31_raddr", DW'(bank_raddr_a), 31);
    tick();
    check("x31_wr_waddr", DW'(bank_waddr), 31);
    check("x31_wr_wdata", bank_wdata, 64'hC0DE_0000_0000_001F);
    check("x31_wr_stall", DW'(stall), 1);
    tick();
    check("x31_end_stall", DW'(stall), 0);
    check("x31_end_state", DW'(state_dbg), DW'(S_IDLE));

    // Pending irq_req across a restore; CPU writes during stall are dropped.
    enter_isr("pend");
    cpu_write(5'd3, 64'hAAAA);
    cpu_write(5'd7, 64'hBBBB);
    irq_req = 1'b1;
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
    check("pend_rd1_state", DW'(state_dbg), DW'(S_RD));
    cpu_we = 1'b1; cpu_waddr = 5'd12; cpu_wdata = 64'hDEAD;
    #1;
    check("pend_rd1_we", DW'(bank_we), 0);
    tick();
    check("pend_wr1_waddr", DW'(bank_waddr), 3);
    check("pend_wr1_wdata", bank_wdata, 64'hC0DE_0000_0000_0003);
    tick();
    check("pend_rd2_we", DW'(bank_we), 0);
    check("pend_rd2_int", DW'(interrupt), 0);
    tick();
    check("pend_wr2_waddr", DW'(bank_waddr), 7);
    cpu_we = 1'b0;
    tick();
    check("pend_end_stall", DW'(stall), 0);
    check("pend_end_state", DW'(state_dbg), DW'(S_IDLE));
    check("pend_end_cnt", DW'(dirty_count), 0);
    tick();
    irq_req = 1'b0;
    check("pend_reentry_state", DW'(state_dbg), DW'(S_ISR));
    check("pend_reentry_ack", DW'(irq_ack), 1);
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
    check("pend_exit_state", DW'(state_dbg), DW'(S_IDLE));

    // Asynchronous reset mid-ISR with three dirty registers.
    enter_isr("arst");
    cpu_write(5'd2, 64'h1);
    cpu_write(5'd4, 64'h2);
    cpu_write(5'd6, 64'h3);
    check("arst_cnt3", DW'(dirty_count), 3);
    #2;
    reset = 1'b0;
    #1;
    check("arst_interrupt", DW'(interrupt), 0);
    check("arst_stall", DW'(stall), 0);
    check("arst_irq_ack", DW'(irq_ack), 0);
    check("arst_cnt", DW'(dirty_count), 0);
    tick();
    reset = 1'b1;
    tick();
    check("arst_idle", DW'(state_dbg), DW'(S_IDLE));
    check("arst_int_after", DW'(interrupt), 0);

    // Asynchronous reset in the middle of a restore.
    enter_isr("rrst");
    cpu_write(5'd8, 64'h4);
    irq_ret = 1'b1;
    tick();
    irq_ret = 1'b0;
    check("rrst_stall_on", DW'(stall), 1);
    #2;
    reset = 1'b0;
    #1;
    check("rrst_stall_off", DW'(stall), 0);
    check("rrst_state", DW'(state_dbg), DW'(S_IDLE));
    tick();
    reset = 1'b1;
    tick();
    check("rrst_cnt", DW'(dirty_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_ctx_ctrl.md
REGBANK_CTX_CTRL -- requirements
Module: regbank_ctx_ctrl

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, number of architectural registers; AW = $clog2(REG_NUM).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, register width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port irq_req  input  1  interrupt request level.
REQ-006 SHALL have port irq_ret  input  1  single-cycle return-from-ISR pulse.
REQ-007 SHALL have port cpu_we / cpu_waddr / cpu_wdata  input  1 / AW / DATA_WIDTH  CPU writeback.
REQ-008 SHALL have port cpu_raddr_a  input  AW  CPU read address, port A.
REQ-009 SHALL have port bank_rdata_a  input  DATA_WIDTH  bank port-A data, combinational from bank_raddr_a.
REQ-010 SHALL have port bank_we / bank_waddr / bank_wdata  output  1 / AW / DATA_WIDTH  bank CPU write port.
REQ-011 SHALL have port bank_raddr_a  output  AW  bank port-A read address.
REQ-012 SHALL have port interrupt  output  1  registered context select to bank (1 = shadow context, main writes blocked).
REQ-013 SHALL have port irq_ack  output  1  one-cycle pulse on ISR entry.
REQ-014 SHALL have port stall  output  1  CPU stall while restoring.
REQ-015 SHALL have port dirty_count  output  AW+1  number of shadow registers pending restore.

Function
REQ-016 SHALL implement FSM states IDLE, ISR, RST_RD, RST_WR.
REQ-017 SHALL keep dirty[REG_NUM-1:0]; dirty[0] SHALL never set.
REQ-018 IDLE: irq_req=1 at edge -> ISR; interrupt=1 and irq_ack=1 in the following cycle; irq_ack low afterwards.
REQ-019 ISR: cpu_we=1 with cpu_waddr!=0 SHALL set dirty[cpu_waddr] at that edge; rewrites of a dirty register SHALL NOT change dirty_count.
REQ-020 ISR: irq_req SHALL be ignored (no nesting); irq_ret outside ISR SHALL be ignored.
REQ-021 ISR + irq_ret: a same-cycle cpu_we SHALL be marked dirty; next state RST_RD if resulting dirty!=0, else IDLE; interrupt SHALL be 0 from the next cycle.
REQ-022 RST_RD: bank_raddr_a = index of lowest set dirty bit; rdata captured into holding register with that index; -> RST_WR.
REQ-023 RST_WR: bank_we=1, bank_waddr=held index, bank_wdata=held data (restores shadow from main; main rewritten with identical value); clear that dirty bit; -> RST_RD if bits remain, else IDLE.
REQ-024 Restore SHALL cost exactly 2 cycles per dirty register; stall=1 throughout RST_RD/RST_WR only.
REQ-025 During stall, cpu_we SHALL be dropped (not forwarded, not marked); irq_req SHALL remain pending and be taken in IDLE the cycle after stall deasserts.
REQ-026 Outside RST_*: bank_we/waddr/wdata = cpu_we/waddr/wdata and bank_raddr_a = cpu_raddr_a, combinationally.
REQ-027 dirty_count SHALL equal popcount(dirty), registered, range 0..REG_NUM-1.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, dirty=0, holding regs 0, interrupt=0, irq_ack=0, stall=0, dirty_count=0, at any time including mid-restore.
REQ-029 Outputs SHALL stay at reset values until first rising clk edge after reset=1.

Verification
REQ-030 Reset: assert reset=0 mid-ISR with 3 dirty -> interrupt, stall, irq_ack, dirty_count all 0 immediately; IDLE after release.
REQ-031 irq_req=1, no writes, irq_ret -> irq_ack 1 cycle, interrupt high until cycle after irq_ret, stall never 1.
REQ-032 ISR writes x5, x9, x5 -> dirty_count=2; irq_ret -> stall 4 cycles; raddr 5 then 9; bank_we with main values of x5 (0xA5) then x9 (0x99); dirty_count 0; IDLE.
REQ-033 ISR write to x0 -> dirty_count stays 0, no restore on irq_ret.
REQ-034 irq_ret with same-cycle cpu_we to x31, no prior writes -> restore of x31 only, 2 stall cycles.
REQ-035 irq_req high throughout restore of 2 registers; cpu_we during stall -> no bank_we from CPU; ISR re-entered 1 cycle after stall falls.
